// File: rtl/ccu_sequencer_if.sv
// Instruction handshake, ALU operand/result and debug-read bus of the CCU sequencer.
interface ccu_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_n;
  logic [7:0]  alu_r;
  logic [3:0]  alu_cc;
  logic        alu_we;
  logic [3:0]  cc_q;
  logic        done;
  logic        err;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  modport slave (
    input  instr_valid, instr, alu_r, alu_cc, alu_we, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_n, cc_q, done, err, dbg_data
  );

  modport master (
    output instr_valid, instr, alu_r, alu_cc, alu_we, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_n, cc_q, done, err, dbg_data
  );
endinterface

// File: rtl/ccu_sequencer.sv
// Instruction sequencer and 8x8 register file feeding the CCU ALU.
// IDLE accepts, EXEC samples the ALU, WB commits the result to the register file.
module ccu_sequencer (
  input  logic             clk,
  input  logic             rst_n,
  ccu_sequencer_if.slave   bus
);

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned OPW  = 4;
  localparam int unsigned CCW  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            w_accept;

  logic [DW-1:0]   r_rf [NREG];
  logic [DW-1:0]   r_alu_a;
  logic [DW-1:0]   r_alu_b;
  logic [OPW-1:0]  r_alu_n;
  logic [AW-1:0]   r_dst;
  logic [DW-1:0]   r_imm;
  logic            r_is_ldi;
  logic [DW-1:0]   r_res;
  logic [CCW-1:0]  r_cc_cap;
  logic            r_we_cap;
  logic [CCW-1:0]  r_cc_q;
  logic            r_err;
  logic            r_ready;
  logic            r_done;

  logic [OPW-1:0]  w_op;
  logic [AW-1:0]   w_dst;
  logic [AW-1:0]   w_src_a;
  logic [AW-1:0]   w_src_b;
  logic [DW-1:0]   w_imm;
  logic            w_is_alu;
  logic            w_is_ldi;
  logic            w_illegal;

  assign w_op      = bus.instr[15:12];
  assign w_dst     = bus.instr[11:9];
  assign w_src_a   = bus.instr[8:6];
  assign w_src_b   = bus.instr[5:3];
  assign w_imm     = bus.instr[7:0];
  assign w_is_alu  = ~w_op[3];
  assign w_is_ldi  = (w_op == OPW'(8));
  assign w_illegal = w_op[3] & (w_op[2:0] != 3'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; illegal words are accepted but leave the FSM in IDLE
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.instr_valid) begin
          w_accept = 1'b1;
          if (w_is_alu)      w_next_state = S_EXEC;
          else if (w_is_ldi) w_next_state = S_WB;
        end
      end
      S_EXEC:  w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake/status flags registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= (w_next_state == S_IDLE);
      r_done  <= (w_next_state == S_WB);
      r_err   <= w_accept & w_illegal;
    end
  end

  // Operand issue, ALU capture and write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) r_rf[i] <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_n  <= '0;
      r_dst    <= '0;
      r_imm    <= '0;
      r_is_ldi <= 1'b0;
      r_res    <= '0;
      r_cc_cap <= '0;
      r_we_cap <= 1'b0;
      r_cc_q   <= '0;
    end else begin
      if (w_accept && w_is_alu) begin
        r_alu_a  <= r_rf[w_src_a];
        r_alu_b  <= r_rf[w_src_b];
        r_alu_n  <= w_op;
        r_dst    <= w_dst;
        r_is_ldi <= 1'b0;
      end
      if (w_accept && w_is_ldi) begin
        r_dst    <= w_dst;
        r_imm    <= w_imm;
        r_is_ldi <= 1'b1;
      end
      if (r_state == S_EXEC) begin
        r_res    <= bus.alu_r;
        r_cc_cap <= bus.alu_cc;
        r_we_cap <= bus.alu_we;
      end
      if (r_state == S_WB) begin
        if (r_is_ldi) begin
          r_rf[r_dst] <= r_imm;
        end else begin
          if (r_we_cap) r_rf[r_dst] <= r_res;
          r_cc_q <= r_cc_cap;
        end
      end
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_n       = r_alu_n;
  assign bus.cc_q        = r_cc_q;
  assign bus.dbg_data    = r_rf[bus.dbg_addr];

endmodule

// File: tb/tb_ccu_sequencer.sv
// Self-checking bench for ccu_sequencer: directed scenarios plus randomized
// instruction streams checked against an architectural register-file model.
module tb_ccu_sequencer;

  logic clk;
  logic rst_n;
  logic tb_we;
  int   errors;
  int   checks;

  logic [7:0] m_rf [8];
  logic [3:0] m_cc;

  ccu_sequencer_if bus ();

  ccu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU standing in for the downstream CCU ALU
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] n);
    case (n)
      4'd0:    return 8'(a + b);
      4'd1:    return 8'(a - b);
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return (a < b) ? a : b;
      4'd6:    return (a > b) ? a : b;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [3:0] cc_fn(input logic [7:0] r, input logic [3:0] n);
    return {1'b0, (n == 4'd6), (r == 8'd0), (n <= 4'd1)};
  endfunction

  assign bus.alu_r  = alu_fn(bus.alu_a, bus.alu_b, bus.alu_n);
  assign bus.alu_cc = cc_fn(bus.alu_r, bus.alu_n);
  assign bus.alu_we = tb_we;

  function automatic logic [15:0] mk_alu(input int op, input int d, input int a, input int b);
    return {4'(op), 3'(d), 3'(a), 3'(b), 3'($urandom)};
  endfunction

  function automatic logic [15:0] mk_ldi(input int d, input int imm);
    return {4'd8, 3'(d), 1'b0, 8'(imm)};
  endfunction

  // Present a word for one edge (caller knows the sequencer is in IDLE)
  task automatic send(input logic [15:0] w);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_cc = 4'h0;
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
    checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_flags done=%b err=%b exp=0,0", bus.done, bus.err); end
    checks++; if (bus.cc_q !== 4'h0) begin errors++; $display("FAIL reset_cc got=%h exp=0", bus.cc_q); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_n} !== 20'h0) begin errors++; $display("FAIL reset_alu a=%h b=%h n=%h exp=0", bus.alu_a, bus.alu_b, bus.alu_n); end
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i); #1;
      checks++; if (bus.dbg_data !== 8'h00) begin errors++; $display("FAIL reset_rf r%0d got=%h exp=00", i, bus.dbg_data); end
    end
  endtask

  task automatic test_ldi();
    logic [15:0] w [2];
    int          dst [2];
    int          imm [2];
    dst = '{1, 2}; imm = '{5, 3};
    for (int k = 0; k < 2; k++) begin
      w[k] = mk_ldi(dst[k], imm[k]);
      send(w[k]);
      m_rf[dst[k]] = 8'(imm[k]);
      @(negedge clk);
      checks++; if (bus.done !== 1'b1 || bus.instr_ready !== 1'b0) begin errors++; $display("FAIL ldi_wb done=%b ready=%b exp=1,0", bus.done, bus.instr_ready); end
      @(negedge clk);
      bus.dbg_addr = 3'(dst[k]); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL ldi_done_width got=%b exp=0", bus.done); end
      checks++; if (bus.dbg_data !== m_rf[dst[k]]) begin errors++; $display("FAIL ldi_rf r%0d got=%h exp=%h", dst[k], bus.dbg_data, m_rf[dst[k]]); end
      checks++; if (bus.cc_q !== m_cc) begin errors++; $display("FAIL ldi_cc got=%b exp=%b", bus.cc_q, m_cc); end
    end
  endtask

  task automatic test_alu_ops();
    int op [3];
    int d [3];
    int sa [3];
    int sb [3];
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    op = '{0, 1, 6}; d = '{3, 1, 4}; sa = '{1, 1, 3}; sb = '{2, 1, 2};
    tb_we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = m_rf[sa[k]]; b = m_rf[sb[k]];
      r = alu_fn(a, b, 4'(op[k]));
      send(mk_alu(op[k], d[k], sa[k], sb[k]));
      @(negedge clk);
      checks++; if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_n !== 4'(op[k])) begin errors++; $display("FAIL alu_issue%0d a=%h b=%h n=%h exp=%h,%h,%h", k, bus.alu_a, bus.alu_b, bus.alu_n, a, b, op[k]); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL alu_exec_done%0d got=%b exp=0", k, bus.done); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL alu_wb_done%0d got=%b exp=1", k, bus.done); end
      m_rf[d[k]] = r;
      m_cc       = cc_fn(r, 4'(op[k]));
      @(negedge clk);
      bus.dbg_addr = 3'(d[k]); #1;
      checks++; if (bus.dbg_data !== m_rf[d[k]]) begin errors++; $display("FAIL alu_rf%0d r%0d got=%h exp=%h", k, d[k], bus.dbg_data, m_rf[d[k]]); end
      checks++; if (bus.cc_q !== m_cc) begin errors++; $display("FAIL alu_cc%0d got=%b exp=%b", k, bus.cc_q, m_cc); end
      checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL alu_ready%0d got=%b exp=1", k, bus.instr_ready); end
    end
    // Directed values from the bring-up sequence
    checks++; if (m_rf[3] !== 8'h08 || m_rf[1] !== 8'h00 || m_rf[4] !== 8'h08 || m_cc !== 4'b0100) begin errors++; $display("FAIL alu_directed r3=%h r1=%h r4=%h cc=%b exp=08,00,08,0100", m_rf[3], m_rf[1], m_rf[4], m_cc); end
  endtask

  task automatic test_illegal();
    logic [3:0] n_before;
    n_before = bus.alu_n;
    send({4'hA, 12'h5A5});
    @(negedge clk);
    checks++; if (bus.err !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL illegal_pulse err=%b done=%b exp=1,0", bus.err, bus.done); end
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got=%b exp=1", bus.instr_ready); end
    checks++; if (bus.cc_q !== m_cc || bus.alu_n !== n_before) begin errors++; $display("FAIL illegal_hold cc=%b n=%h exp=%b,%h", bus.cc_q, bus.alu_n, m_cc, n_before); end
    // Next LDI accepted on the very next edge
    bus.instr_valid = 1'b1;
    bus.instr       = mk_ldi(7, 8'hC3);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    m_rf[7] = 8'hC3;
    @(negedge clk);
    checks++; if (bus.err !== 1'b0 || bus.done !== 1'b1) begin errors++; $display("FAIL illegal_next err=%b done=%b exp=0,1", bus.err, bus.done); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i); #1;
      checks++; if (bus.dbg_data !== m_rf[i]) begin errors++; $display("FAIL illegal_rf r%0d got=%h exp=%h", i, bus.dbg_data, m_rf[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit         exp_rdy [6];
    int         acc;
    logic [7:0] r;
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    acc = 0;
    tb_we = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = mk_alu(0, 6, 3, 2);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (bus.instr_ready !== exp_rdy[k]) begin errors++; $display("FAIL b2b_ready cyc%0d got=%b exp=%b", k, bus.instr_ready, exp_rdy[k]); end
      if (bus.instr_ready === 1'b1) acc++;
    end
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r = alu_fn(m_rf[3], m_rf[2], 4'd0);
      m_rf[6] = r;
      m_cc = cc_fn(r, 4'd0);
    end
    checks++; if (acc !== 2) begin errors++; $display("FAIL b2b_accepts got=%0d exp=2", acc); end
    @(negedge clk);
    bus.dbg_addr = 3'd6; #1;
    checks++; if (bus.dbg_data !== m_rf[6] || bus.cc_q !== m_cc) begin errors++; $display("FAIL b2b_result r6=%h cc=%b exp=%h,%b", bus.dbg_data, bus.cc_q, m_rf[6], m_cc); end
  endtask

  task automatic test_reset_mid();
    int dn;
    send(mk_ldi(5, 8'h7F));
    repeat (2) @(negedge clk);
    bus.dbg_addr = 3'd5; #1;
    checks++; if (bus.dbg_data !== 8'h7F) begin errors++; $display("FAIL rstmid_preload got=%h exp=7f", bus.dbg_data); end
    tb_we = 1'b1;
    send(mk_alu(0, 5, 1, 2));
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.dbg_data !== 8'h00 || bus.cc_q !== 4'h0) begin errors++; $display("FAIL rstmid_state r5=%h cc=%b exp=00,0", bus.dbg_data, bus.cc_q); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_n} !== 20'h0 || bus.done !== 1'b0 || bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_out a=%h b=%h n=%h done=%b ready=%b", bus.alu_a, bus.alu_b, bus.alu_n, bus.done, bus.instr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    checks++; if (dn !== 0 || bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after done_cnt=%0d ready=%b exp=0,1", dn, bus.instr_ready); end
    #1;
    checks++; if (bus.dbg_data !== m_rf[5]) begin errors++; $display("FAIL rstmid_rf r5=%h exp=%h", bus.dbg_data, m_rf[5]); end
  endtask

  task automatic test_random();
    int         mode, op, d, sa, sb, imm;
    logic [7:0] a, b, r;
    for (int t = 0; t < 200; t++) begin
      mode = $urandom_range(0, 9);
      d  = $urandom_range(0, 7); sa = $urandom_range(0, 7); sb = $urandom_range(0, 7);
      checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready t%0d got=%b exp=1", t, bus.instr_ready); end
      if (mode <= 5) begin
        op = $urandom_range(0, 7);
        tb_we = ($urandom_range(0, 3) != 0);
        a = m_rf[sa]; b = m_rf[sb];
        r = alu_fn(a, b, 4'(op));
        send(mk_alu(op, d, sa, sb));
        @(negedge clk);
        checks++; if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_n !== 4'(op) || bus.done !== 1'b0) begin errors++; $display("FAIL rnd_exec t%0d a=%h b=%h n=%h done=%b exp=%h,%h,%h,0", t, bus.alu_a, bus.alu_b, bus.alu_n, bus.done, a, b, op); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rnd_alu_done t%0d got=%b exp=1", t, bus.done); end
        if (tb_we) m_rf[d] = r;
        m_cc = cc_fn(r, 4'(op));
      end else if (mode <= 7) begin
        imm = $urandom_range(0, 255);
        send(mk_ldi(d, imm));
        m_rf[d] = 8'(imm);
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rnd_ldi_done t%0d got=%b exp=1", t, bus.done); end
      end else begin
        op = $urandom_range(9, 15);
        send({4'(op), 12'($urandom)});
        @(negedge clk);
        checks++; if (bus.err !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL rnd_illegal t%0d err=%b done=%b exp=1,0", t, bus.err, bus.done); end
      end
      @(posedge clk);
      #1 bus.dbg_addr = 3'(d);
      #1;
      checks++; if (bus.dbg_data !== m_rf[d] || bus.cc_q !== m_cc) begin errors++; $display("FAIL rnd_state t%0d r%0d=%h cc=%b exp=%h,%b", t, d, bus.dbg_data, bus.cc_q, m_rf[d], m_cc); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    tb_we  = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.dbg_addr    = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_ldi();
    test_alu_ops();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccu_sequencer.md
# ccu_sequencer

Instruction sequencer and 8×8 register file that sits directly upstream of the CCU ALU. It accepts 16-bit instruction words over a valid/ready handshake and reads two source registers. It drives the ALU operand and opcode buses, captures the ALU result, condition codes and write enable, and writes the result back into the register file. It also supports load-immediate and flags illegal opcodes.

## Interface
- No parameters. Data width is fixed at 8 bits, with 8 registers and 16-bit instructions.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction word present
- instr_ready  out  1  sequencer can accept; high only in IDLE
- instr  in  16  [15:12] op, [11:9] dst, [8:6] srcA, [5:3] srcB, [2:0] ignored; for LDI, [7:0] is imm
- alu_a  out  8  operand A to ALU (registered)
- alu_b  out  8  operand B to ALU (registered)
- alu_n  out  4  ALU opcode, 0–7 only (registered)
- alu_r  in  8  ALU result (combinational from alu_a/alu_b/alu_n)
- alu_cc  in  4  ALU condition codes
- alu_we  in  1  ALU write enable
- cc_q  out  4  last captured ALU condition codes
- done  out  1  high for the single WB cycle of every accepted legal instruction
- err  out  1  one-cycle pulse on acceptance of an illegal opcode
- dbg_addr  in  3  debug read address
- dbg_data  out  8  combinational rf[dbg_addr]

## Operation
- **Opcodes.**
  - op 0–7: ALU op. alu_n = op, and the result goes to rf[dst].
  - op 8: LDI, meaning rf[dst] = instr[7:0].
  - op 9–15: illegal.
- **FSM states:** IDLE, EXEC, WB.
- **IDLE.** instr_ready=1. When instr_valid=1, the instruction is accepted at that edge.
  - ALU op: alu_a <= rf[srcA], alu_b <= rf[srcB], alu_n <= op. Latch dst. Next state EXEC.
  - LDI: latch dst and imm. Next state WB.
  - Illegal: err pulses the next cycle. No other state changes. Stay in IDLE.
- **EXEC.** instr_ready=0. At the end of the cycle, capture alu_r, alu_cc and alu_we into internal registers. Next state WB.
- **WB.** instr_ready=0 and done=1. At the end of the cycle:
  - ALU op: if the captured we=1, rf[dst] <= captured r. cc_q <= captured cc, always.
  - LDI: rf[dst] <= imm. cc_q is unchanged.
  - Next state IDLE.
- **Register rules.**
  - All 8 registers are general purpose. r0 is not hardwired.
  - dst may equal srcA or srcB. Sources are read at acceptance, so the old value is used.
- alu_a, alu_b and alu_n hold their last values outside acceptance. They are never driven with op ≥ 8.
- instr_valid or instr changes while not in IDLE are ignored. The upstream holds the word until ready.
- Arithmetic is performed entirely by the ALU. The sequencer performs no width extension; all paths are 8 bits.

## Timing
- **Reset (async assert, sync-safe deassert) forces:**
  - state IDLE and all rf entries 0x00
  - alu_a, alu_b, alu_n = 0, and cc_q = 0
  - done = 0, err = 0, instr_ready = 1 once reset is deasserted
- **Reset mid-operation** (EXEC or WB): the instruction is abandoned, there is no register write, and cc_q is 0.
- **Latency, counted from the acceptance edge:**
  - ALU op: EXEC during cycle 1, WB (done=1) during cycle 2. The write is visible on dbg_data in cycle 3, and the next accept is possible at the end of cycle 3.
  - LDI: WB during cycle 1, visible in cycle 2.
- Throughput is one ALU op per 3 cycles, one LDI per 2 cycles, or one illegal per cycle.
- Back-to-back dependence needs no forwarding, because each write completes before the next acceptance.
- dbg_data is combinational. It reflects a write from the edge ending WB.

## Test plan
- Reset, then LDI r1=0x05 and LDI r2=0x03 → dbg r1=0x05, r2=0x03. cc_q stays 0000. done is high one cycle each, 1 cycle after acceptance.
- ADD (op 0) dst=r3, srcA=r1, srcB=r2 → alu_a=0x05, alu_b=0x03, alu_n=0 in EXEC. Then r3=0x08 and cc_q=0001. done is in cycle 2 after acceptance.
- SUB (op 1) dst=r1, srcA=r1, srcB=r1 → r1=0x00 and cc_q=0011. Then MAX (op 6) dst=r4, srcA=r3, srcB=r2 → r4=0x08 and cc_q=0100.
- Illegal op 0xA → err pulses once, there is no done, and rf and cc_q are unchanged. instr_ready stays 1, and the next LDI is accepted on the following cycle.
- Hold instr_valid=1 for 6 cycles with an ADD word → exactly two acceptances, at cycles 0 and 3. instr_ready pattern is 1,0,0,1,0,0.
- Assert rst_n=0 during EXEC of ADD dst=r5 (r5 preloaded 0x7F) → r5=0x00 (reset), there is no done, state is IDLE, and outputs are at reset values.
